lf_cmd_rx: RTL

- Parametrised successor to the LF command/config front end.
- Receives ARM command frames over SPI by oversampling spck/ncs/mosi in the pck0 domain; replaces the asynchronous posedge-ncs/posedge-spck logic.
- Decodes commands into the config, divisor and threshold registers; checks frame length; supports register readback on miso.
- Blanks the mode outputs for a programmable window on every major-mode change, so downstream mode muxes never see glitches.

---
 rtl/lf_cmd_rx.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/lf_cmd_rx.sv
// LF command/config front end: oversampled SPI receiver in the pck0 domain that
// decodes command frames into config registers, with readback and mode blanking.
module lf_cmd_rx #(
  parameter int FRAME_W           = 16,
  parameter int CMD_W             = 4,
  parameter int SYNC_STAGES       = 2,
  parameter int BLANK_CYCLES      = 4,
  parameter int DIV_DEFAULT       = 95,
  parameter int ED_THRESH_DEFAULT = 127,
  parameter int ERR_CNT_W         = 4
) (
  input  logic                       pck0,
  input  logic                       rst,
  input  logic                       spck,
  input  logic                       ncs,
  input  logic                       mosi,
  output logic                       miso,
  output logic [FRAME_W-CMD_W-1:0]   conf_word,
  output logic [2:0]                 major_mode,
  output logic                       lf_field,
  output logic                       lf_ed_toggle_mode,
  output logic [7:0]                 divisor,
  output logic [7:0]                 lf_ed_threshold,
  output logic                       mode_valid,
  output logic                       cfg_strobe,
  output logic                       frame_err,
  output logic [ERR_CNT_W-1:0]       err_count
);

  localparam int DATA_W  = FRAME_W - CMD_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);

  logic [SYNC_STAGES-1:0] spck_sync_reg, ncs_sync_reg, mosi_sync_reg;
  logic                   spck_d_reg, ncs_d_reg;
  logic                   armed_reg, rx_active_reg, commit_reg;
  logic [CNT_W-1:0]       bit_cnt_reg;
  logic [FRAME_W-1:0]     rx_sreg_reg, tx_sreg_reg;
  logic [DATA_W-1:0]      conf_word_reg;
  logic [7:0]             divisor_reg, threshold_reg;
  logic [BLANK_W-1:0]     blank_cnt_reg;
  logic                   mode_valid_reg, cfg_strobe_reg, frame_err_reg;
  logic [ERR_CNT_W-1:0]   err_count_reg;

  logic spck_s, ncs_s, mosi_s;
  logic spck_rise, spck_fall, ncs_rise, ncs_fall;
  logic [CMD_W-1:0]   cmd;
  logic [DATA_W-1:0]  data;
  logic               len_ok, mode_change;
  logic [FRAME_W-1:0] rb_val;

  assign spck_s    = spck_sync_reg[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_reg[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
  assign spck_rise = spck_s & ~spck_d_reg;
  assign spck_fall = ~spck_s & spck_d_reg;
  assign ncs_rise  = ncs_s & ~ncs_d_reg;
  assign ncs_fall  = ~ncs_s & ncs_d_reg;

  assign cmd         = rx_sreg_reg[FRAME_W-1 -: CMD_W];
  assign data        = rx_sreg_reg[DATA_W-1:0];
  assign len_ok      = (bit_cnt_reg == CNT_W'(FRAME_W));
  assign mode_change = commit_reg && len_ok && (cmd == CMD_W'(1)) &&
                       (data[8:6] != conf_word_reg[8:6]);

  always_comb begin
    rb_val = '0;
    case (data[1:0])
      2'd0:    rb_val = FRAME_W'(conf_word_reg);
      2'd1:    rb_val = FRAME_W'(divisor_reg);
      2'd2:    rb_val = FRAME_W'(threshold_reg);
      default: rb_val = FRAME_W'({err_count_reg, mode_valid_reg, conf_word_reg[8:6]});
    endcase
  end

  always_ff @(posedge pck0) begin
    if (rst) begin
      // Synced ncs resets low so a frame held open across reset never arms the receiver.
      spck_sync_reg  <= '0;
      ncs_sync_reg   <= '0;
      mosi_sync_reg  <= '0;
      spck_d_reg     <= 1'b0;
      ncs_d_reg      <= 1'b0;
      armed_reg      <= 1'b0;
      rx_active_reg  <= 1'b0;
      commit_reg     <= 1'b0;
      bit_cnt_reg    <= '0;
      rx_sreg_reg    <= '0;
      tx_sreg_reg    <= '0;
      conf_word_reg  <= '0;
      divisor_reg    <= 8'(DIV_DEFAULT);
      threshold_reg  <= 8'(ED_THRESH_DEFAULT);
      blank_cnt_reg  <= BLANK_W'(BLANK_CYCLES);
      mode_valid_reg <= 1'b0;
      cfg_strobe_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      err_count_reg  <= '0;
    end else begin
      spck_sync_reg <= {spck_sync_reg[SYNC_STAGES-2:0], spck};
      ncs_sync_reg  <= {ncs_sync_reg[SYNC_STAGES-2:0], ncs};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
      spck_d_reg    <= spck_s;
      ncs_d_reg     <= ncs_s;
      if (ncs_s)
        armed_reg <= 1'b1;

      // Only a frame whose ncs fall was seen while armed can reach commit.
      if (ncs_fall && armed_reg) begin
        rx_active_reg <= 1'b1;
        bit_cnt_reg   <= '0;
      end else if (ncs_rise) begin
        rx_active_reg <= 1'b0;
      end
      commit_reg <= ncs_rise & rx_active_reg;

      if (spck_rise && !ncs_s && rx_active_reg) begin
        rx_sreg_reg <= {rx_sreg_reg[FRAME_W-2:0], mosi_s};
        if (bit_cnt_reg != CNT_W'(FRAME_W + 1))
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end

      cfg_strobe_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      if (spck_fall && !ncs_s)
        tx_sreg_reg <= {tx_sreg_reg[FRAME_W-2:0], 1'b0};

      if (commit_reg) begin
        if (!len_ok) begin
          frame_err_reg <= 1'b1;
          if (err_count_reg != '1)
            err_count_reg <= err_count_reg + 1'b1;
        end else begin
          tx_sreg_reg <= '0;
          case (cmd)
            CMD_W'(1): begin
              conf_word_reg  <= data;
              cfg_strobe_reg <= 1'b1;
              if (data[8:6] == 3'd1)
                threshold_reg <= 8'(ED_THRESH_DEFAULT);
            end
            CMD_W'(2): begin
              divisor_reg    <= data[7:0];
              cfg_strobe_reg <= 1'b1;
            end
            CMD_W'(3): begin
              threshold_reg  <= data[7:0];
              cfg_strobe_reg <= 1'b1;
            end
            CMD_W'(4): tx_sreg_reg <= rb_val;
            default: ;
          endcase
        end
      end

      // mode_valid rises on the same edge the counter lands on zero.
      if (mode_change) begin
        blank_cnt_reg  <= BLANK_W'(BLANK_CYCLES);
        mode_valid_reg <= 1'b0;
      end else if (blank_cnt_reg != '0) begin
        blank_cnt_reg  <= blank_cnt_reg - 1'b1;
        mode_valid_reg <= (blank_cnt_reg == BLANK_W'(1));
      end else begin
        mode_valid_reg <= 1'b1;
      end
    end
  end

  assign miso              = tx_sreg_reg[FRAME_W-1];
  assign conf_word         = conf_word_reg;
  assign major_mode        = conf_word_reg[8:6];
  assign lf_field          = conf_word_reg[0];
  assign lf_ed_toggle_mode = conf_word_reg[1];
  assign divisor           = divisor_reg;
  assign lf_ed_threshold   = threshold_reg;
  assign mode_valid        = mode_valid_reg;
  assign cfg_strobe        = cfg_strobe_reg;
  assign frame_err         = frame_err_reg;
  assign err_count         = err_count_reg;

endmodule
